// File: rtl/mux4_rr_collector_if.sv
// ---------------------------------------------------------------------------
// mux4_rr_collector_if
//   Bundle of the handshake and data signals between the four sources, the
//   4:1 collector, and the downstream consumer.
//
//   Modports:
//     master : the collector side. It drives in_ready and the output stage,
//              and receives the source offers and downstream ready.
//     slave  : the environment side (sources plus consumer).
//
//   Signals:
//     in_valid [3:0]         channel i offers a word
//     in_data  [4*WIDTH-1:0] channel i word in bits [i*WIDTH +: WIDTH]
//     in_ready [3:0]         channel i word accepted this cycle
//     out_valid              output register holds a word
//     out_data [WIDTH-1:0]   registered word
//     out_s0 / out_s1        granted channel index {s1,s0} (demux select)
//     out_ready              downstream accepts the word
//     xfer_cnt [15:0]        accepted-word count, wraps modulo 2^16
// ---------------------------------------------------------------------------
interface mux4_rr_collector_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_s0;
  logic               out_s1;
  logic               out_ready;
  logic [15:0]        xfer_cnt;

  modport master (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_s0,
    output out_s1,
    output xfer_cnt
  );

  modport slave (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_s0,
    input  out_s1,
    input  xfer_cnt
  );
endinterface

// File: rtl/mux4_rr_collector.sv
// ---------------------------------------------------------------------------
// mux4_rr_collector
//   4-channel to 1-channel collector, the return path for the 1-to-4 demux.
//   Four sources offer words over valid/ready. An arbiter grants one source
//   per transfer, and its word is loaded into a single registered output
//   stage together with the granted channel index {out_s1,out_s0}. That index
//   is encoded exactly as the demux select, so a downstream demux can route
//   the word back to the same lane.
//
//   Build option:
//     MUX4_FIXED_PRIO_EN undefined (default): round-robin arbitration. The
//       search starts at rr_ptr and rr_ptr advances past each grant.
//     MUX4_FIXED_PRIO_EN defined: fixed priority, where channel 0 is highest.
//       rr_ptr is not built in this variant.
//
//   Ports:
//     clk    : single clock; all state updates on the rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : mux4_rr_collector_if.master. It carries in_valid/in_data/
//              in_ready, out_valid/out_data/out_s0/out_s1/out_ready and
//              xfer_cnt.
//
//   Timing:
//     - in_ready is combinational.
//     - An accepted word appears on out_data one cycle after its handshake.
//     - A full output register can drain and refill in the same cycle, which
//       gives 1 word/cycle sustained.
// ---------------------------------------------------------------------------
module mux4_rr_collector #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux4_rr_collector_if.master     bus
);

  // Output stage and counter state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_idx_q,   out_idx_d;
  logic [15:0]      xfer_cnt_q,  xfer_cnt_d;

`ifndef MUX4_FIXED_PRIO_EN
  logic [1:0]       rr_ptr_q,    rr_ptr_d;
`endif

  // Arbitration / handshake signals
  logic             load;
  logic             any_valid;
  logic             accept;
  logic [1:0]       grant;
  logic [WIDTH-1:0] grant_word;

  // The register accepts a new word whenever it is empty or being drained.
  assign load      = !out_valid_q || bus.out_ready;
  assign any_valid = |bus.in_valid;
  // rst_n is folded in so that no source sees a handshake while reset is held.
  assign accept    = rst_n && load && any_valid;

`ifndef MUX4_FIXED_PRIO_EN
  // Round-robin: take the first valid channel in the order
  // rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
  always_comb begin
    logic       found;
    logic [1:0] cand;
    grant = rr_ptr_q;
    found = 1'b0;
    cand  = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!found && bus.in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: the lowest-index valid channel wins.
  always_comb begin
    if (bus.in_valid[0])      grant = 2'd0;
    else if (bus.in_valid[1]) grant = 2'd1;
    else if (bus.in_valid[2]) grant = 2'd2;
    else                      grant = 2'd3;
  end
`endif

  assign grant_word = bus.in_data[int'(grant)*WIDTH +: WIDTH];

  // At most one ready bit is set: the granted channel, and only on a load.
  always_comb begin
    bus.in_ready = 4'b0000;
    if (accept) begin
      bus.in_ready[grant] = 1'b1;
    end
  end

  // Next-state logic for the output stage, counter and pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    xfer_cnt_d  = xfer_cnt_q;
`ifndef MUX4_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    if (load) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_word;
        out_idx_d   = grant;
        xfer_cnt_d  = xfer_cnt_q + 16'd1;
`ifndef MUX4_FIXED_PRIO_EN
        rr_ptr_d    = grant + 2'd1;
`endif
      end else begin
        // Drained with nothing to refill. Data, index and pointer keep
        // their last values.
        out_valid_d = 1'b0;
      end
    end
  end

  // ---- stage boundary: registered output ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 2'd0;
      xfer_cnt_q  <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

`ifndef MUX4_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_s0    = out_idx_q[0];
  assign bus.out_s1    = out_idx_q[1];
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux4_rr_collector.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_collector
//   Scoreboard bench for mux4_rr_collector. Stimulus pushes the expected
//   {data, index, count} at each handshake. A monitor pops one entry for each
//   word the DUT hands downstream. Both builds are covered through
//   MUX4_FIXED_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_mux4_rr_collector;

  logic clk;
  logic rst_n;

  mux4_rr_collector_if #(.WIDTH(8)) bus ();

  mux4_rr_collector #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  idx;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_cnt  = 16'd0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(logic [7:0] d, logic [1:0] idx);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.data = d;
    e.idx  = idx;
    e.cnt  = exp_cnt;
    q.push_back(e);
  endtask

  task automatic set_word(int ch, logic [7:0] w);
    bus.in_data[ch*8 +: 8] = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a word leaves the DUT on the coming edge when valid && ready.
  // Inputs change only just after rising edges, so the falling edge sees
  // the values that the next rising edge will use.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: actual data=%0h idx=%0d required no word",
                 bus.out_data, {bus.out_s1, bus.out_s0});
      end else begin
        mon_e = q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_e.data));
        check("out_idx",  32'({bus.out_s1, bus.out_s0}), 32'(mon_e.idx));
        check("xfer_cnt", 32'(bus.xfer_cnt), 32'(mon_e.cnt));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state, and no ready while reset is held
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    check("rst_in_ready",  32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_data",  32'(bus.out_data), 32'h0);
    check("rst_out_idx",   32'({bus.out_s1, bus.out_s0}), 32'h0);
    check("rst_xfer_cnt",  32'(bus.xfer_cnt), 32'h0);
    bus.in_valid = 4'b0000;
    tick();
    rst_n = 1'b1;

    // Single source on channel 2
    bus.in_valid = 4'b0100;
    set_word(2, 8'hA5);
    #1;
    check("single_in_ready", 32'(bus.in_ready), 32'b0100);
    push_exp(8'hA5, 2'd2);
    tick();
    bus.in_valid = 4'b0000;
    check("single_out_valid", 32'(bus.out_valid), 32'h1);

    // Pointer wrap: grant 3, then both 0 and 3 requesting
    bus.in_valid = 4'b1000;
    set_word(3, 8'h63);
    #1;
    check("wrap_g3_ready", 32'(bus.in_ready), 32'b1000);
    push_exp(8'h63, 2'd3);
    tick();
    bus.in_valid = 4'b1001;
    set_word(0, 8'h60);
    #1;
    check("wrap_a_ready", 32'(bus.in_ready), 32'b0001);
    push_exp(8'h60, 2'd0);
    tick();
    set_word(0, 8'h10);
    #1;
`ifndef MUX4_FIXED_PRIO_EN
    check("wrap_b_ready", 32'(bus.in_ready), 32'b1000);
    push_exp(8'h63, 2'd3);
`else
    check("wrap_b_ready", 32'(bus.in_ready), 32'b0001);
    push_exp(8'h10, 2'd0);
`endif
    tick();

    // All four requesting for 8 cycles
    for (int i = 0; i < 4; i++) set_word(i, 8'(8'h10 + i));
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
`ifndef MUX4_FIXED_PRIO_EN
      check("fair_in_ready", 32'(bus.in_ready), 32'(4'b0001 << (i % 4)));
      push_exp(8'(8'h10 + (i % 4)), 2'(i % 4));
`else
      check("fair_in_ready", 32'(bus.in_ready), 32'b0001);
      push_exp(8'h10, 2'd0);
`endif
      tick();
    end
    bus.in_valid = 4'b0000;
    tick();
    check("drain_out_valid", 32'(bus.out_valid), 32'h0);
`ifndef MUX4_FIXED_PRIO_EN
    check("drain_hold_data", 32'(bus.out_data), 32'h13);
`else
    check("drain_hold_data", 32'(bus.out_data), 32'h10);
`endif

    // Backpressure: hold 0x33 while channel 1 waits
    bus.in_valid = 4'b0001;
    set_word(0, 8'h33);
    #1;
    check("bp_load_ready", 32'(bus.in_ready), 32'b0001);
    push_exp(8'h33, 2'd0);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0010;
    set_word(1, 8'h44);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready",  32'(bus.in_ready), 32'h0);
      check("bp_out_data",  32'(bus.out_data), 32'h33);
      check("bp_out_valid", 32'(bus.out_valid), 32'h1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'b0010);
    push_exp(8'h44, 2'd1);
    tick();
    bus.in_valid = 4'b0000;

    // Counter wrap: stream channel 0 until the count rolls to 0
    bus.in_valid = 4'b0001;
    for (int i = 0; i < 65522; i++) begin
      set_word(0, 8'(i));
      push_exp(8'(i), 2'd0);
      tick();
    end
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    check("cnt_wrap", 32'(bus.xfer_cnt), 32'h0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'h1);

    // Asynchronous reset in mid-cycle discards the held word
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_out_data",  32'(bus.out_data), 32'h0);
    check("arst_out_idx",   32'({bus.out_s1, bus.out_s0}), 32'h0);
    check("arst_xfer_cnt",  32'(bus.xfer_cnt), 32'h0);
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'h0);
    q.delete();
    exp_cnt = 16'd0;
    rst_n = 1'b1;
    bus.in_valid = 4'b0010;
    set_word(1, 8'h77);
    #1;
    check("post_rst_ready", 32'(bus.in_ready), 32'b0010);
    push_exp(8'h77, 2'd1);
    tick();
    bus.in_valid = 4'b0000;
    tick();
    tick();
    check("post_rst_cnt", 32'(bus.xfer_cnt), 32'h1);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_collector.md
Name: mux4_rr_collector

Overview:
- 4-channel to 1-channel collector; the return path for the team's 1-to-4 demux.
- Each of four sources offers a word with a valid/ready handshake. A round-robin arbiter grants one source per transfer and loads its word into a single registered output stage.
- The output also carries the granted channel index as {s1,s0}, encoded exactly as the demux select. A downstream demux can therefore route the word back to the same lane.

Parameters:
- WIDTH, 8, data width of every input channel and of the output.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  4  in_valid[i]: channel i offers a word
- in_data  input  4*WIDTH  channel i word in bits [i*WIDTH +: WIDTH]
- in_ready  output  4  in_ready[i]: channel i word is accepted this cycle
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered word
- out_s0  output  1  granted channel index bit 0 (demux s0)
- out_s1  output  1  granted channel index bit 1 (demux s1)
- out_ready  input  1  downstream accepts the word
- xfer_cnt  output  16  count of accepted input words, wraps modulo 2^16

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_s0=0, out_s1=0, xfer_cnt=0, rr_ptr=0.
- in_ready is combinational from in_valid, out_valid, out_ready and rr_ptr. While rst_n=0, all in_ready bits are 0.
- Load enable: load = !out_valid || out_ready.
  - A full register can drain and refill in the same cycle.
  - Sustained throughput is 1 word/cycle.
- Arbitration (round-robin):
  - Search order is rr_ptr, rr_ptr+1, ..., rr_ptr+3, all modulo 4.
  - grant g is the first channel in that order with in_valid set.
  - At most one in_ready bit is high: in_ready[g] = load && in_valid[g].
- On a clock edge with load=1 and any in_valid set:
  - out_data <= word of channel g.
  - {out_s1,out_s0} <= g.
  - out_valid <= 1.
  - rr_ptr <= (g+1) mod 4 (wraps 3 -> 0).
  - xfer_cnt <= xfer_cnt+1 (wraps 0xFFFF -> 0x0000).
- On a clock edge with load=1 and no in_valid set: out_valid <= 0. out_data, out_s0, out_s1 and rr_ptr hold.
- On a clock edge with load=0 (out_valid=1, out_ready=0): all outputs hold; all in_ready bits are 0.
- Latency: an accepted word appears on out_data one cycle after its in_valid/in_ready handshake.
- Sources must hold in_valid and in_data stable until in_ready is seen.
- Output stall: the output holds stable while out_valid=1 and out_ready=0.
- Simultaneous requests: only channel g is accepted. The other channels wait; the rotating rr_ptr bounds each channel's wait to 3 grants.
- Reset asserted mid-transfer: the pending output word is discarded and the block returns to the reset state immediately.

Optional Feature:
- Macro: MUX4_FIXED_PRIO_EN.
- Defined: fixed priority, channel 0 highest, then 1, 2, 3. rr_ptr is not implemented and has no effect; g is the lowest-index valid channel.
- Undefined (default): round-robin arbitration as described in Behaviour.
- The handshake, latency, counter and reset behaviour are identical in both builds.

Test Plan:
- Reset then single source: after rst_n release, in_valid=4'b0100, data2=8'hA5, out_ready=1. Required: in_ready=4'b0100. Next cycle out_valid=1, out_data=8'hA5, {out_s1,out_s0}=2'b10, xfer_cnt=1.
- All-request fairness: in_valid=4'b1111 held, data_i=8'h10+i, out_ready=1, 8 cycles. Required output sequence 10,11,12,13,10,11,12,13 with s-index 0,1,2,3,0,1,2,3 and xfer_cnt=8. With MUX4_FIXED_PRIO_EN defined, the required sequence is all 8'h10.
- Backpressure: out_ready=0 while out_valid=1 holding 8'h33, in_valid=4'b0010. Required: in_ready=0 and out_data stays 8'h33 across 5 cycles. Raise out_ready, then the channel 1 word appears the next cycle.
- Pointer wrap: grant channel 3, then in_valid=4'b1001. Required: next grant is channel 0 (rr_ptr wrapped to 0), then channel 3.
- Counter wrap and async reset: preload 65535 transfers, then one more. Required: xfer_cnt=16'h0000. Pulse rst_n low mid-cycle with out_valid=1. Required: out_valid=0 and out_data=0 immediately, without waiting for a clk edge.
